// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXE/MEM/WB sequencing of IFU, regfile, ALU and data memory.
// Optional build macro MC_CTRL_ILLEGAL_TRAP_EN: unsupported instructions trap into HALT instead of running as NOPs.
module mc_ctrl #(
   parameter logic [2:0] RESET_STATE = 3'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       PCWr,
   output logic [1:0] nPC_sel,
   output logic       j_sel,
   output logic       IRWr,
   output logic       RegWr,
   output logic [1:0] RegDst,
   output logic [1:0] MemToReg,
   output logic       ALUSrc,
   output logic [1:0] ALUOp,
   output logic       ExtOp,
   output logic       MemWr,
   output logic       instr_done,
   output logic       halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef struct packed {
      logic       pcwr;
      logic [1:0] npc_sel;
      logic       j_sel;
      logic       irwr;
      logic       regwr;
      logic [1:0] regdst;
      logic [1:0] memtoreg;
      logic       alusrc;
      logic [1:0] aluop;
      logic       extop;
      logic       memwr;
      logic       done;
      logic       halted;
   } ctrl_t;

   state_t r_state;
   state_t w_next;
   ctrl_t  w_ctl;
   ctrl_t  w_out;

   logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
   logic w_legal;
   logic [1:0] w_aluop;
   logic       w_alusrc, w_extop;

   assign w_rtype = (op == 6'b000000);
   assign w_addu  = w_rtype && (funct == 6'b100001);
   assign w_subu  = w_rtype && (funct == 6'b100011);
   assign w_jr    = w_rtype && (funct == 6'b001000);
   assign w_ori   = (op == 6'b001101);
   assign w_lui   = (op == 6'b001111);
   assign w_lw    = (op == 6'b100011);
   assign w_sw    = (op == 6'b101011);
   assign w_beq   = (op == 6'b000100);
   assign w_j     = (op == 6'b000010);
   assign w_jal   = (op == 6'b000011);
   assign w_legal = w_addu | w_subu | w_jr | w_ori | w_lui | w_lw | w_sw | w_beq | w_j | w_jal;

   // ALU controls of the current instruction; driven in EXE and held again in WB.
   always_comb begin
      w_aluop  = 2'b00;
      w_alusrc = 1'b0;
      w_extop  = 1'b0;
      if (w_subu) begin
         w_aluop = 2'b01;
      end else if (w_ori) begin
         w_aluop  = 2'b10;
         w_alusrc = 1'b1;
      end else if (w_lui) begin
         w_aluop  = 2'b11;
         w_alusrc = 1'b1;
      end else if (w_lw || w_sw) begin
         w_alusrc = 1'b1;
         w_extop  = 1'b1;
      end else if (w_beq) begin
         w_aluop = 2'b01;
         w_extop = 1'b1;
      end
   end

   // NOTE: state flops use non-blocking assignment; the async reset lands on FETCH without waiting for clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= state_t'(RESET_STATE);
      else     r_state <= w_next;
   end

   // NOTE: every output and the next state get a default first, so no path through the case infers a latch.
   always_comb begin
      w_next = r_state;
      w_ctl  = '0;
      unique case (r_state)
         S_FETCH: begin
            w_ctl.irwr = 1'b1;
            w_next     = S_DECODE;
         end
         S_DECODE: begin
            if (w_j || w_jal) begin
               w_ctl.pcwr  = 1'b1;
               w_ctl.j_sel = 1'b1;
               w_ctl.done  = 1'b1;
               if (w_jal) begin
                  w_ctl.regwr    = 1'b1;
                  w_ctl.regdst   = 2'b10;
                  w_ctl.memtoreg = 2'b10;
               end
               w_next = S_FETCH;
            end else if (w_jr) begin
               w_ctl.pcwr    = 1'b1;
               w_ctl.npc_sel = 2'b11;
               w_ctl.done    = 1'b1;
               w_next        = S_FETCH;
            end else if (!w_legal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               w_next = S_HALT;
`else
               w_ctl.pcwr = 1'b1;
               w_ctl.done = 1'b1;
               w_next     = S_FETCH;
`endif
            end else begin
               w_next = S_EXE;
            end
         end
         S_EXE: begin
            w_ctl.aluop  = w_aluop;
            w_ctl.alusrc = w_alusrc;
            w_ctl.extop  = w_extop;
            if (w_beq) begin
               w_ctl.pcwr    = 1'b1;
               w_ctl.npc_sel = zero ? 2'b01 : 2'b00;
               w_ctl.done    = 1'b1;
               w_next        = S_FETCH;
            end else if (w_lw || w_sw) begin
               w_next = S_MEM;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            if (w_sw) begin
               w_ctl.memwr = 1'b1;
               w_ctl.pcwr  = 1'b1;
               w_ctl.done  = 1'b1;
               w_next      = S_FETCH;
            end else if (w_lw) begin
               w_next = S_WB;
            end else begin
               w_next = S_FETCH;
            end
         end
         S_WB: begin
            w_ctl.regwr    = 1'b1;
            w_ctl.pcwr     = 1'b1;
            w_ctl.done     = 1'b1;
            w_ctl.aluop    = w_aluop;
            w_ctl.alusrc   = w_alusrc;
            w_ctl.extop    = w_extop;
            w_ctl.regdst   = w_rtype ? 2'b01 : 2'b00;
            w_ctl.memtoreg = w_lw ? 2'b01 : 2'b00;
            w_next         = S_FETCH;
         end
         S_HALT: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            w_ctl.halted = 1'b1;
            w_next       = S_HALT;
`else
            w_next = S_FETCH;
`endif
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Reset silences every strobe immediately, independent of the state register.
   assign w_out = rst ? '0 : w_ctl;

   assign PCWr       = w_out.pcwr;
   assign nPC_sel    = w_out.npc_sel;
   assign j_sel      = w_out.j_sel;
   assign IRWr       = w_out.irwr;
   assign RegWr      = w_out.regwr;
   assign RegDst     = w_out.regdst;
   assign MemToReg   = w_out.memtoreg;
   assign ALUSrc     = w_out.alusrc;
   assign ALUOp      = w_out.aluop;
   assign ExtOp      = w_out.extop;
   assign MemWr      = w_out.memwr;
   assign instr_done = w_out.done;
   assign halted     = w_out.halted;

endmodule
